// File: rtl/posit_seq_pkg.sv
// posit_seq_pkg: shared opcodes, FSM states and status-word layout for the posit op sequencer
// Ports: none (package). Provides op_t, state_t, ST_* status bit indices and op_legal().
package posit_seq_pkg;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_TIMEOUT = 2;
    localparam int ST_ILLEGAL = 3;
    localparam int ST_COUNT   = 8;
    localparam int ST_ACK     = 31;

    // Only the four arithmetic codes exist; anything above div is rejected.
    function automatic logic op_legal(input logic [31:0] op);
        return op <= 32'(OP_DIV);
    endfunction

endpackage

// File: rtl/posit_seq_timer.sv
// posit_seq_timer: clear/enable cycle counter that saturates at TIMEOUT and flags expiry
// Ports: clock, reset (async, active-high), clear (sync zero), enable (count), expired (count == TIMEOUT).
module posit_seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    assign expired = cnt == TW'(TIMEOUT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/posit_op_sequencer.sv
// posit_op_sequencer: issues HPS-written posit commands to the arithmetic unit and publishes status
// Ports: clock, reset (async, active-high); io_num1/io_num2/io_ctrl from the PIOs; io_result and
// io_status back to the PIOs; io_unit_* valid/ready request, response and flush towards the posit unit.
import posit_seq_pkg::*;

module posit_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_num1,
    input  logic [WIDTH-1:0] io_num2,
    input  logic [31:0]      io_ctrl,
    output logic [WIDTH-1:0] io_result,
    output logic [31:0]      io_status,
    output logic             io_unit_req_valid,
    input  logic             io_unit_req_ready,
    output logic [OPW-1:0]   io_unit_op,
    output logic [WIDTH-1:0] io_unit_a,
    output logic [WIDTH-1:0] io_unit_b,
    input  logic             io_unit_resp_valid,
    input  logic [WIDTH-1:0] io_unit_result,
    output logic             io_unit_flush
);

    state_t     state;
    logic       busy, done, timeout, illegal, ack, go;
    logic [7:0] count;
    logic       expired, accept, legal, finish, abort;
    logic       unused_ctrl;

    assign unused_ctrl = ^io_ctrl[30:OPW];

    posit_seq_timer #(.TIMEOUT(TIMEOUT)) timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == S_IDLE),
        .enable  (state != S_IDLE),
        .expired (expired)
    );

    assign legal  = op_legal(32'(io_ctrl[OPW-1:0]));
    assign accept = state == S_IDLE && io_ctrl[31] != ack;
    assign finish = state == S_WAIT && io_unit_resp_valid;
    // A response in the expiry cycle still counts as success.
    assign abort  = state != S_IDLE && expired && !finish;

    always_comb begin
        io_status                 = '0;
        io_status[ST_BUSY]        = busy;
        io_status[ST_DONE]        = done;
        io_status[ST_TIMEOUT]     = timeout;
        io_status[ST_ILLEGAL]     = illegal;
        io_status[ST_COUNT +: 8]  = count;
        io_status[ST_ACK]         = ack;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            timeout           <= 1'b0;
            illegal           <= 1'b0;
            ack               <= 1'b0;
            go                <= 1'b0;
            count             <= '0;
            io_result         <= '0;
            io_unit_req_valid <= 1'b0;
            io_unit_op        <= '0;
            io_unit_a         <= '0;
            io_unit_b         <= '0;
            io_unit_flush     <= 1'b0;
        end else begin
            io_unit_flush <= 1'b0;
            if (accept) begin
                io_unit_op        <= io_ctrl[OPW-1:0];
                io_unit_a         <= io_num1;
                io_unit_b         <= io_num2;
                go                <= io_ctrl[31];
                timeout           <= 1'b0;
                illegal           <= !legal;
                done              <= !legal;
                busy              <= legal;
                io_unit_req_valid <= legal;
                if (legal)
                    state <= S_ISSUE;
                else
                    ack <= io_ctrl[31];
            end
            if (state == S_ISSUE && !abort && io_unit_req_ready) begin
                io_unit_req_valid <= 1'b0;
                state             <= S_WAIT;
            end
            if (finish || abort) begin
                state             <= S_IDLE;
                busy              <= 1'b0;
                ack               <= go;
                io_unit_req_valid <= 1'b0;
            end
            if (finish) begin
                io_result <= io_unit_result;
                done      <= 1'b1;
                count     <= count + 8'd1;
            end
            if (abort) begin
                timeout       <= 1'b1;
                io_unit_flush <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_posit_op_sequencer.sv
// tb_posit_op_sequencer: scoreboard bench driving directed posit commands through a scripted unit model
module tb_posit_op_sequencer;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] io_num1, io_num2, io_ctrl, io_result, io_status;
    logic        io_unit_req_valid, io_unit_req_ready, io_unit_resp_valid, io_unit_flush;
    logic [2:0]  io_unit_op;
    logic [31:0] io_unit_a, io_unit_b, io_unit_result;

    posit_op_sequencer #(.WIDTH(32), .OPW(3), .TIMEOUT(TO)) dut (
        .clock              (clk),
        .reset              (reset),
        .io_num1            (io_num1),
        .io_num2            (io_num2),
        .io_ctrl            (io_ctrl),
        .io_result          (io_result),
        .io_status          (io_status),
        .io_unit_req_valid  (io_unit_req_valid),
        .io_unit_req_ready  (io_unit_req_ready),
        .io_unit_op         (io_unit_op),
        .io_unit_a          (io_unit_a),
        .io_unit_b          (io_unit_b),
        .io_unit_resp_valid (io_unit_resp_valid),
        .io_unit_result     (io_unit_result),
        .io_unit_flush      (io_unit_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] st;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    int          pass_n = 0;
    int          total_n = 0;
    logic        tog = 1'b0;
    logic [7:0]  m_count = 8'd0;
    logic [31:0] m_result = 32'd0;

    function automatic logic [31:0] sword(input logic a, input logic [7:0] c,
                                          input logic ill, input logic to, input logic dn);
        return {a, 15'd0, c, 4'd0, ill, to, dn, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act === exp)
            pass_n++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " result/status"}, {io_result, io_status}, 64'd0);
        chk({tag, " unit a/b"}, {io_unit_a, io_unit_b}, 64'd0);
        chk({tag, " valid/op/flush"}, {io_unit_req_valid, io_unit_op, io_unit_flush}, 64'd0);
    endtask

    // Completion monitor: every ack flip is one finished command.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset)
                prev = 1'b0;
            else if (io_status[31] !== prev) begin
                prev = io_status[31];
                if (q.size() == 0) begin
                    total_n++;
                    $display("FAIL unexpected completion: status %h with no command pending", io_status);
                end else begin
                    e = q.pop_front();
                    chk("status", io_status, e.st);
                    chk("result", io_result, e.res);
                end
            end
        end
    end

    // rdly: ready-low cycles once req_valid shows (-1 never ready); rspd: WAIT cycles before
    // the response (-1 never); mid: toggles applied while busy (1 = retarget to illegal op 6).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input int rdly, input int rspd, input int mid, input logic [31:0] r);
        bit ill = op > 3'd3;
        bit to = !ill && (rdly < 0 || rdly >= TO || rspd < 0 || 1 + rdly + rspd > TO);
        int exp_held = ill ? 0 : (rdly < 0 || rdly >= TO) ? TO + 1 : rdly + 1;
        int exp_busy = ill ? 0 : to ? TO + 1 : rdly + rspd + 2;
        int held = 0;
        int busy_n = 0;
        int flush_n = 0;
        int wc = 0;
        bit stable = 1'b1;
        bit fin = 1'b0;
        tog = ~tog;
        if (!ill && !to) begin
            m_count++;
            m_result = r;
        end
        q.push_back('{sword(tog, m_count, ill, to, !to), m_result});
        @(negedge clk);
        io_num1 = a;
        io_num2 = b;
        io_ctrl = {tog, 28'd0, op};
        io_unit_req_ready = 1'b0;
        io_unit_resp_valid = 1'b0;
        for (int c = 0; c < TO + 10 && !fin; c++) begin
            @(negedge clk);
            busy_n += int'(io_status[0]);
            flush_n += int'(io_unit_flush);
            if (io_unit_req_valid) begin
                held++;
                if ({io_unit_op, io_unit_a, io_unit_b} !== {op, a, b})
                    stable = 1'b0;
            end
            io_unit_req_ready = io_unit_req_valid && rdly >= 0 && held > rdly;
            io_unit_resp_valid = 1'b0;
            if (io_status[0] && !io_unit_req_valid) begin
                io_unit_resp_valid = wc == rspd;
                io_unit_result = r;
                if (wc == 0 && mid > 0) begin
                    tog = ~tog;
                    io_ctrl = {tog, 28'd0, 3'd6};
                    if (mid == 1)
                        q.push_back('{sword(tog, m_count, 1'b1, 1'b0, 1'b1), m_result});
                end
                if (wc == 1 && mid == 2) begin
                    tog = ~tog;
                    io_ctrl[31] = tog;
                end
                wc++;
            end
            fin = !io_status[0];
        end
        io_unit_req_ready = 1'b0;
        io_unit_resp_valid = 1'b0;
        @(negedge clk);
        flush_n += int'(io_unit_flush);
        chk("completion seen", 64'(fin), 64'd1);
        chk("req cycles", 64'(held), 64'(exp_held));
        if (exp_held > 0)
            chk("op/a/b stable", 64'(stable), 64'd1);
        chk("busy cycles", 64'(busy_n), 64'(exp_busy));
        chk("flush pulses", 64'(flush_n), 64'(to));
        if (mid == 1)
            chk("back-to-back accept", io_status, sword(tog, m_count, 1'b1, 1'b0, 1'b1));
        if (mid == 2)
            chk("double toggle ignored", {io_status[0], io_unit_req_valid}, 64'd0);
    endtask

    initial begin
        int flush_n;
        reset = 1'b1;
        io_num1 = '0;
        io_num2 = '0;
        io_ctrl = '0;
        io_unit_req_ready = 1'b0;
        io_unit_resp_valid = 1'b0;
        io_unit_result = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        #2 reset = 1'b0;

        do_op(32'h4000_0000, 32'h4000_0000, 3'd0, 0, 3, 0, 32'h4800_0000);
        chk("add status word", io_status, 64'h8000_0102);
        do_op(32'h3F80_0000, 32'h4040_0000, 3'd2, 10, 1, 0, 32'h4100_0000);

        @(negedge clk);
        io_unit_resp_valid = 1'b1;
        io_unit_result = 32'hDEAD_BEEF;
        @(negedge clk);
        io_unit_resp_valid = 1'b0;
        @(negedge clk);
        chk("stale resp ignored", {io_status[0], io_result}, {1'b0, m_result});

        do_op(32'h1111_1111, 32'h2222_2222, 3'd1, -1, 0, 0, 32'h3333_3333);
        chk("timeout status word", io_status, sword(tog, m_count, 1'b0, 1'b1, 1'b0));
        do_op(32'h4444_4444, 32'h5555_5555, 3'd3, 0, -1, 0, 32'h6666_6666);
        do_op(32'h0A0A_0A0A, 32'h0B0B_0B0B, 3'd1, 2, TO - 3, 0, 32'h0C0C_0C0C);
        do_op(32'h0D0D_0D0D, 32'h0E0E_0E0E, 3'd2, 2, TO - 2, 0, 32'h0F0F_0F0F);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 0, 0, 0, 32'h0);
        do_op(32'h5000_0000, 32'h4000_0000, 3'd3, 0, 4, 2, 32'h4800_0000);
        repeat (3) @(negedge clk);
        chk("no second command", {io_status[0], io_unit_req_valid}, 64'd0);
        do_op(32'h4800_0000, 32'h4000_0000, 3'd0, 1, 2, 1, 32'h4C00_0000);

        @(negedge clk);
        tog = ~tog;
        io_ctrl = {tog, 28'd0, 3'd2};
        io_unit_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        io_unit_req_ready = 1'b0;
        chk("in WAIT before reset", {io_status[0], io_unit_req_valid}, 64'd2);
        #2 reset = 1'b1;
        #1 chk_zero("async reset");
        io_ctrl = '0;
        tog = 1'b0;
        m_count = 8'd0;
        m_result = 32'd0;
        q.delete();
        flush_n = 0;
        repeat (2) begin
            @(negedge clk);
            flush_n += int'(io_unit_flush);
        end
        #2 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            flush_n += int'(io_unit_flush);
        end
        chk("no flush after reset", 64'(flush_n), 64'd0);

        for (int i = 0; i < 256; i++)
            do_op(32'(i), ~32'(i), 3'(i % 4), 0, 0, 0, 32'(i * 3));
        chk("count wrapped", io_status[15:8], 64'd0);
        chk("queue drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
